// File: rtl/anton_neopixel_stream.sv
// Streams bytes from a raw pixel buffer as a NeoPixel (WS2812-style) serial waveform,
// MSB first, followed by a low latch period that ends with a one-cycle sync pulse.

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 8191
`endif

module anton_neopixel_stream #(
    parameter int  BUFFER_END  = `BUFFER_END_DEFAULT,
    parameter int  T_BIT       = 25,
    parameter int  T_0H        = 8,
    parameter int  T_1H        = 16,
    parameter int  T_SYNC      = 1000,
    localparam int BUFFER_BITS = `CLOG2(BUFFER_END + 1)
) (
    input  logic                   busClk,
    input  logic                   busResetN,
    input  logic [12:0]            regMax,
    input  logic                   regCtrlInit,
    input  logic                   regCtrlLimit,
    input  logic                   regCtrlRun,
    input  logic                   regCtrl32bit,
    output logic [BUFFER_BITS-1:0] pixelIxComb,
    input  logic [7:0]             pixelByte,
    output logic                   streamSyncOf,
    output logic                   state,
    output logic                   neoData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_BIT,
        S_SYNC
    } state_e;

    localparam int CW    = (BUFFER_BITS + 1 > 13) ? BUFFER_BITS + 1 : 13;
    localparam int T_MAX = (T_BIT > T_SYNC) ? T_BIT : T_SYNC;
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    state_e                 state_q, state_d;
    logic [BUFFER_BITS-1:0] index_q, index_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_q, bit_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   limit_en_q, limit_en_d;
    logic                   mode32_q, mode32_d;
    logic                   neo_q, neo_d;

    // Index arithmetic is done wider than the buffer index so next/limit never wrap.
    logic [CW-1:0] idx_w, next_w, max_w, end_w, limit_w;
    logic          last_byte;

    assign idx_w     = CW'(index_q);
    assign next_w    = (mode32_q && idx_w[1:0] == 2'd2) ? idx_w + CW'(2) : idx_w + CW'(1);
    assign max_w     = CW'(regMax);
    assign end_w     = CW'(BUFFER_END);
    assign limit_w   = (limit_en_q && max_w < end_w) ? max_w : end_w;
    assign last_byte = (idx_w >= limit_w) || (next_w > limit_w);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        index_d    = index_q;
        shift_d    = shift_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        limit_en_d = limit_en_q;
        mode32_d   = mode32_q;

        unique case (state_q)
            S_IDLE: begin
                index_d = '0;
                cnt_d   = '0;
                bit_d   = '0;
                if (regCtrlRun) begin
                    state_d    = S_FETCH;
                    limit_en_d = regCtrlLimit;
                    mode32_d   = regCtrl32bit;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                shift_d = pixelByte;
                bit_d   = 3'd7;
                cnt_d   = '0;
                state_d = S_BIT;
            end
            S_BIT: begin
                if (cnt_q == CNT_W'(T_BIT - 1)) begin
                    cnt_d = '0;
                    if (bit_q != 3'd0) begin
                        bit_d   = bit_q - 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                    end else if (last_byte) begin
                        state_d = S_SYNC;
                    end else begin
                        index_d = next_w[BUFFER_BITS-1:0];
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SYNC: begin
                if (cnt_q == CNT_W'(T_SYNC - 1)) begin
                    cnt_d   = '0;
                    index_d = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (regCtrlInit) begin
            state_d = S_IDLE;
            index_d = '0;
            cnt_d   = '0;
            bit_d   = '0;
        end

        // Line level is computed for the upcoming cycle so the registered output lines up with the state.
        neo_d = (state_d == S_BIT) &&
                (cnt_d < (shift_d[7] ? CNT_W'(T_1H) : CNT_W'(T_0H)));
    end

    always_ff @(posedge busClk or negedge busResetN) begin
        if (!busResetN) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            shift_q    <= '0;
            bit_q      <= '0;
            cnt_q      <= '0;
            limit_en_q <= 1'b0;
            mode32_q   <= 1'b0;
            neo_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q    <= state_d;
            index_q    <= index_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            limit_en_q <= limit_en_d;
            mode32_q   <= mode32_d;
            neo_q      <= neo_d;
        end
    end

    assign pixelIxComb  = index_q;
    assign state        = (state_q != S_IDLE);
    assign neoData      = neo_q;
    assign streamSyncOf = (state_q == S_SYNC) && (cnt_q == CNT_W'(T_SYNC - 1)) && !regCtrlInit;

endmodule

// File: tb/tb_anton_neopixel_stream.sv
// Bench for anton_neopixel_stream: a frame-level reference model expands each frame into
// an expected per-cycle trace of {state, neoData, streamSyncOf} and buffer index.

module tb_anton_neopixel_stream;

    localparam int TB   = 10;
    localparam int T0   = 3;
    localparam int T1   = 6;
    localparam int TS   = 20;
    localparam int BE_A = 7;
    localparam int BE_B = 3;
    localparam int BYTE_CYC = 2 + 8 * TB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] reg_max;
    logic        init, limit_en, run, m32;
    logic [2:0]  ix_a;
    logic [1:0]  ix_b;
    logic [7:0]  pix_a, pix_b;
    logic        sync_a, state_a, neo_a;
    logic        sync_b, state_b, neo_b;
    logic [7:0]  mem [8];
    logic        sel_b;
    logic [2:0]  obs_sig;
    logic [2:0]  obs_ix;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] sig;
        int         ix;
    } cyc_t;

    cyc_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pix_a <= mem[ix_a];
        pix_b <= mem[{1'b0, ix_b}];
    end

    assign obs_sig = sel_b ? {state_b, neo_b, sync_b} : {state_a, neo_a, sync_a};
    assign obs_ix  = sel_b ? {1'b0, ix_b} : ix_a;

    anton_neopixel_stream #(
        .BUFFER_END(BE_A), .T_BIT(TB), .T_0H(T0), .T_1H(T1), .T_SYNC(TS)
    ) u_dut_a (
        .busClk(clk), .busResetN(rst_n), .regMax(reg_max),
        .regCtrlInit(init), .regCtrlLimit(limit_en), .regCtrlRun(run), .regCtrl32bit(m32),
        .pixelIxComb(ix_a), .pixelByte(pix_a),
        .streamSyncOf(sync_a), .state(state_a), .neoData(neo_a)
    );

    anton_neopixel_stream #(
        .BUFFER_END(BE_B), .T_BIT(TB), .T_0H(T0), .T_1H(T1), .T_SYNC(TS)
    ) u_dut_b (
        .busClk(clk), .busResetN(rst_n), .regMax(reg_max),
        .regCtrlInit(init), .regCtrlLimit(limit_en), .regCtrlRun(run), .regCtrl32bit(m32),
        .pixelIxComb(ix_b), .pixelByte(pix_b),
        .streamSyncOf(sync_b), .state(state_b), .neoData(neo_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [2:0] sig, input int ix);
        cyc_t c;
        c.sig = sig;
        c.ix  = ix;
        exp_q.push_back(c);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push(3'b000, 0);
    endtask

    // Expected trace of one frame, starting with the first FETCH cycle.
    task automatic push_frame(input int be);
        int   lim, idx, nxt;
        bit   done;
        int   bytes[$];
        logic [7:0] bv;
        lim  = (limit_en && int'(reg_max) < be) ? int'(reg_max) : be;
        idx  = 0;
        done = 1'b0;
        while (!done) begin
            bytes.push_back(idx);
            nxt = (m32 && (idx % 4) == 2) ? idx + 2 : idx + 1;
            if (idx >= lim || nxt > lim) done = 1'b1;
            else idx = nxt;
        end
        foreach (bytes[k]) begin
            bv = mem[bytes[k]];
            push(3'b100, bytes[k]);
            push(3'b100, bytes[k]);
            for (int b = 7; b >= 0; b--)
                for (int c = 0; c < TB; c++)
                    push({1'b1, c < (bv[b] ? T1 : T0), 1'b0}, bytes[k]);
        end
        for (int c = 0; c < TS; c++) push({1'b1, 1'b0, c == TS - 1}, -1);
    endtask

    task automatic play(input string tag, input int drop_at, input int stop_at);
        int n;
        n = (stop_at < exp_q.size()) ? stop_at : exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s sig c%0d", tag, i), 32'(obs_sig), 32'(exp_q[i].sig));
            if (exp_q[i].ix >= 0)
                check($sformatf("%s ix c%0d", tag, i), 32'(obs_ix), exp_q[i].ix);
            if (i == drop_at) run = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        init = 1'b0; run = 1'b0; limit_en = 1'b0; m32 = 1'b0;
        reg_max = '0;
        sel_b = 1'b0;
        randomize_mem();

        repeat (3) @(negedge clk);
        check("reset sig a", 32'({state_a, neo_a, sync_a}), 0);
        check("reset ix a", 32'(ix_a), 0);
        check("reset sig b", 32'({state_b, neo_b, sync_b}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle after reset", 32'(obs_sig), 0);

        // Single 0xA5 byte with limit on, regMax 0, one-cycle run pulse.
        mem[0] = 8'hA5; limit_en = 1'b1; reg_max = 13'd0;
        push_frame(BE_A); push_idle(5);
        run = 1'b1;
        play("a5", 0, 1 << 20);

        // 32-bit mode skips every fourth byte: indices 0,1,2,4,5.
        randomize_mem(); reg_max = 13'd5; m32 = 1'b1;
        push_frame(BE_A); push_idle(5);
        run = 1'b1;
        play("skip32", 0, 1 << 20);

        // Run held: back-to-back frames with one IDLE cycle, run dropped mid second frame.
        randomize_mem(); reg_max = 13'd1; m32 = 1'b0;
        push_frame(BE_A); push_idle(1);
        push_frame(BE_A); push_idle(5);
        run = 1'b1;
        play("loop", 2 * BYTE_CYC + TS + 1 + 30, 1 << 20);

        // Randomised frames.
        for (int f = 0; f < 4; f++) begin
            randomize_mem();
            reg_max  = 13'($urandom_range(0, 9));
            limit_en = 1'($urandom_range(0, 1));
            m32      = 1'($urandom_range(0, 1));
            push_frame(BE_A); push_idle(4);
            run = 1'b1;
            play($sformatf("rnd%0d", f), 0, 1 << 20);
        end

        // Init during bit 3 of byte 2.
        randomize_mem(); limit_en = 1'b0; m32 = 1'b0;
        push_frame(BE_A);
        run = 1'b1;
        play("init", 0, 2 * BYTE_CYC + 2 + 4 * TB + 5);
        init = 1'b1;
        @(negedge clk);
        check("init sig", 32'(obs_sig), 0);
        check("init ix", 32'(obs_ix), 0);
        @(negedge clk);
        init = 1'b0;
        push_idle(TS + 10);
        play("post init", -1, 1 << 20);

        // Reset pulse in the middle of SYNC, then a fresh frame from index 0.
        randomize_mem(); limit_en = 1'b1; reg_max = 13'd0;
        push_frame(BE_A);
        run = 1'b1;
        play("pre rst", 0, BYTE_CYC + 5);
        #2 rst_n = 1'b0;
        #1;
        check("rst mid sync sig", 32'(obs_sig), 0);
        check("rst mid sync ix", 32'(obs_ix), 0);
        @(negedge clk);
        check("rst held sig", 32'(obs_sig), 0);
        rst_n = 1'b1;
        run = 1'b1;
        push_frame(BE_A); push_idle(3);
        play("post rst", 0, 1 << 20);

        // Small buffer, limit off: regMax ignored, bytes 0..3.
        sel_b = 1'b1;
        randomize_mem(); limit_en = 1'b0; reg_max = 13'd100; m32 = 1'b0;
        push_frame(BE_B); push_idle(3);
        run = 1'b1;
        play("bufend", 0, 1 << 20);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        sel_b = 1'b0;
        @(negedge clk);
        check("final idle a", 32'(obs_sig), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
